// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, phase encoding and default durations shared by traffic_phase_ctrl
package traffic_pkg;
  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN = 2'b10;
  typedef enum logic [1:0] {
    PH_GREEN = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALL_RED = 2'b10,
    PH_WALK = 2'b11
  } phase_t;
  localparam int DEF_NUM_WAYS = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_MIN_GREEN = 4;
  localparam int DEF_MAX_GREEN = 16;
  localparam int DEF_YELLOW_TIME = 3;
  localparam int DEF_ALL_RED_TIME = 2;
  localparam int DEF_WALK_TIME = 6;
endpackage

// File: rtl/traffic_phase_ctrl_rr_next_way.sv
// rr_next_way: finds the first requesting way after k, wrapping around and ending at k itself
module rr_next_way #(
  parameter int NUM_WAYS = 4,
  parameter int KW = $clog2(NUM_WAYS)
) (
  input logic [NUM_WAYS-1:0] req,
  input logic [KW-1:0] k,
  output logic [KW-1:0] nxt,
  output logic none
);
  logic [NUM_WAYS-1:0] rot;
  int off;
  // rot[p] is the request of way k+1+p (mod NUM_WAYS), so rot[NUM_WAYS-1] is way k
  assign rot = NUM_WAYS'({req, req} >> k >> 1);
  assign none = ~|req;
  always_comb begin
    off = NUM_WAYS - 1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) off = rot[i] ? i : off;
    nxt = KW'((int'(k) + 1 + off) % NUM_WAYS);
  end
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin multi-approach signal sequencer with min/max green timing.
// Defining PED_WALK_EN adds the pedestrian WALK phase with ped_req/walk ports.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
  parameter int WALK_TIME = DEF_WALK_TIME
) (
  input logic clk,
  input logic rst,
`ifdef PED_WALK_EN
  input logic ped_req,
  output logic walk,
`endif
  input logic [NUM_WAYS-1:0] req,
  output logic [2*NUM_WAYS-1:0] lights,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [1:0] phase
);
  localparam int KW = $clog2(NUM_WAYS);
  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_T = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_TIME - 1);
  localparam logic [2*NUM_WAYS-1:0] RST_LIGHTS = {{(NUM_WAYS-1){RED}}, GREEN};
  phase_t st, nxt_st;
  logic [KW-1:0] k, nxt_k, pick;
  logic [CNT_W-1:0] timer, nxt_timer;
  logic [2*NUM_WAYS-1:0] nxt_lights;
  logic none, other, ped_due;
  rr_next_way #(.NUM_WAYS(NUM_WAYS), .KW(KW)) u_rr (.req(req), .k(k), .nxt(pick), .none(none));
  assign phase = st;
  assign active_way = k;
`ifdef PED_WALK_EN
  logic ped_pend;
  assign ped_due = ped_pend;
`else
  assign ped_due = 1'b0;
`endif
  // a side road always counts as demand so control returns to way 0
  always_comb begin
    other = |(req & ~(NUM_WAYS'(1) << k)) || k != '0 || ped_due;
    nxt_st = st;
    nxt_k = k;
    case (st)
      PH_GREEN: nxt_st = (timer >= MIN_T && other && (!req[k] || timer >= MAX_T)) ? PH_YELLOW : PH_GREEN;
      PH_YELLOW: nxt_st = (timer == YEL_T) ? PH_ALL_RED : PH_YELLOW;
      PH_ALL_RED: if (timer == AR_T) begin
        nxt_st = ped_due ? PH_WALK : PH_GREEN;
        nxt_k = ped_due ? k : none ? '0 : pick;
      end
      default: nxt_st = (timer == WALK_T) ? PH_ALL_RED : PH_WALK;
    endcase
    nxt_timer = (nxt_st != st) ? '0 : (&timer) ? timer : timer + 1'b1;
    nxt_lights = {NUM_WAYS{RED}};
    if (nxt_st == PH_GREEN || nxt_st == PH_YELLOW) nxt_lights[2*nxt_k +: 2] = (nxt_st == PH_GREEN) ? GREEN : YELLOW;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= PH_GREEN;
      k <= '0;
      timer <= '0;
      lights <= RST_LIGHTS;
`ifdef PED_WALK_EN
      ped_pend <= 1'b0;
      walk <= 1'b0;
`endif
    end else begin
      st <= nxt_st;
      k <= nxt_k;
      timer <= nxt_timer;
      lights <= nxt_lights;
`ifdef PED_WALK_EN
      ped_pend <= ped_req || (ped_pend && !(nxt_st == PH_WALK && st != PH_WALK));
      walk <= nxt_st == PH_WALK;
`endif
    end
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: random-stimulus scoreboard bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;
  localparam int N = 4;
  localparam int CW = 8;
  localparam int MING = 4;
  localparam int MAXG = 16;
  localparam int YT = 3;
  localparam int ART = 2;
  localparam int WT = 6;
  typedef struct packed {
    logic [2*N-1:0] lights;
    logic [1:0] way;
    logic [1:0] phase;
    logic walk;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] lights;
  logic [1:0] active_way;
  logic [1:0] phase;
`ifdef PED_WALK_EN
  logic walk;
`endif
  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int m_way = 0;
  int m_ph = 0;
  int m_t = 0;
  bit m_ped = 1'b0;

  traffic_phase_ctrl #(
    .NUM_WAYS(N), .CNT_W(CW), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .WALK_TIME(WT)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef PED_WALK_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .req(req),
    .lights(lights),
    .active_way(active_way),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // m_ph: 0 green, 1 yellow, 2 all-red, 3 walk; m_t counts cycles already spent in the phase
  task automatic model_step(input logic [N-1:0] r, input logic p, input logic rs);
    int nph;
    int nway;
    bit other;
    if (rs) begin
      m_way = 0;
      m_ph = 0;
      m_t = 0;
      m_ped = 1'b0;
      return;
    end
    other = (m_way != 0) || m_ped;
    for (int d = 0; d < N; d++) if (d != m_way && r[d]) other = 1'b1;
    nph = m_ph;
    nway = m_way;
    if (m_ph == 0 && m_t + 1 >= MING && other && (!r[m_way] || m_t + 1 >= MAXG)) nph = 1;
    else if (m_ph == 1 && m_t + 1 == YT) nph = 2;
    else if (m_ph == 2 && m_t + 1 == ART) begin
      if (m_ped) nph = 3;
      else begin
        nph = 0;
        nway = 0;
        for (int d = N; d >= 1; d--) if (r[(m_way + d) % N]) nway = (m_way + d) % N;
      end
    end else if (m_ph == 3 && m_t + 1 == WT) nph = 2;
    m_ped = (nph == 3 && m_ph != 3) ? p : (m_ped | p);
    m_t = (nph != m_ph) ? 0 : m_t + 1;
    m_ph = nph;
    m_way = nway;
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.lights = '0;
    if (m_ph == 0) e.lights[2*m_way +: 2] = 2'b10;
    if (m_ph == 1) e.lights[2*m_way +: 2] = 2'b01;
    e.way = 2'(m_way);
    e.phase = 2'(m_ph);
    e.walk = (m_ph == 3);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(req, ped_req, rst);
    q.push_back(expected());
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("lights", 16'(lights), 16'(mon_e.lights));
      chk("active_way", 16'(active_way), 16'(mon_e.way));
      chk("phase", 16'(phase), 16'(mon_e.phase));
`ifdef PED_WALK_EN
      chk("walk", 16'(walk), 16'(mon_e.walk));
`endif
    end
  end

  initial begin
    repeat (2) cycle();
    rst = 1'b0;
    repeat (50) cycle();
    req = 4'b0100;
    repeat (30) cycle();
    req = 4'b1011;
    repeat (80) cycle();
    req = 4'b1000;
    repeat (12) cycle();
    req = 4'b0000;
    repeat (20) cycle();
    repeat (700) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      rst = ($urandom_range(0, 79) == 0);
`ifdef PED_WALK_EN
      ped_req = ($urandom_range(0, 24) == 0);
`endif
      cycle();
    end
    rst = 1'b0;
    req = '0;
    ped_req = 1'b0;
    repeat (3) cycle();
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
